// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: byte-serial loaded instruction memory with registered fetch outputs
module inst_fetch_unit #(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic [7:0]                input_data,
  input  logic                      input_start,
  input  logic                      input_end,
  input  logic                      input_valid,
  output logic [31:0]               inst,
  output logic                      inst_enable,
  output logic [INST_MEM_WIDTH-1:0] pc_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next
);
  localparam int W = INST_MEM_WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] addr_q, addr_d, pc_next_d, pc1_next_d;
  logic [1:0] cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] inst_d;
  logic inst_enable_d, we;
  logic [31:0] mem [2**W];
  // a restart request wins over a byte arriving in the same cycle
  assign we = state_q == LOAD && !input_start && input_valid && cnt_q == 2'd3;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    inst_d = inst;
    inst_enable_d = inst_enable;
    pc_next_d = pc_next;
    pc1_next_d = pc1_next;
    if (input_start) begin
      state_d = LOAD;
      addr_d = '0;
      cnt_d = '0;
      inst_enable_d = 1'b0;
    end else if (state_q == LOAD) begin
      if (input_valid) begin
        shift_d = {shift_q[15:0], input_data};
        cnt_d = cnt_q + 2'd1;
        addr_d = we ? addr_q + W'(1) : addr_q;
      end
      if (input_end) begin
        state_d = RUN;
        cnt_d = '0;
      end
    end else if (state_q == RUN) begin
      inst_d = mem[pc];
      inst_enable_d = 1'b1;
      pc_next_d = pc + W'(1);
      pc1_next_d = pc1 + W'(1);
    end
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      shift_q <= '0;
      inst <= '0;
      inst_enable <= 1'b0;
      pc_next <= '0;
      pc1_next <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      inst <= inst_d;
      inst_enable <= inst_enable_d;
      pc_next <= pc_next_d;
      pc1_next <= pc1_next_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (we) mem[addr_q] <= {shift_q, input_data};
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed loader/fetch stimulus checked against a behavioural model
module tb_inst_fetch_unit;
  logic CLK = 0, reset = 1;
  logic [1:0] pc = 0, pc1 = 1;
  logic [7:0] input_data = 0;
  logic input_start = 0, input_end = 0, input_valid = 0;
  logic [31:0] inst;
  logic inst_enable;
  logic [1:0] pc_next, pc1_next;
  int checks = 0, failures = 0;
  bit chk_on = 0;

  inst_fetch_unit #(.INST_MEM_WIDTH(2)) dut (
    .CLK(CLK), .reset(reset), .pc(pc), .pc1(pc1), .input_data(input_data),
    .input_start(input_start), .input_end(input_end), .input_valid(input_valid),
    .inst(inst), .inst_enable(inst_enable), .pc_next(pc_next), .pc1_next(pc1_next)
  );

  always #5 CLK = ~CLK;

  logic [31:0] m_mem [4] = '{default: 0};
  logic [31:0] m_word = 0, exp_inst = 0;
  logic [1:0] exp_pn = 0, exp_p1n = 0;
  logic exp_en = 0;
  bit loading = 0, running = 0;
  int m_addr = 0, m_bytes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    if (reset) begin
      loading = 0; running = 0; m_bytes = 0;
      exp_inst = 0; exp_en = 0; exp_pn = 0; exp_p1n = 0;
    end else if (input_start) begin
      loading = 1; running = 0; m_addr = 0; m_bytes = 0; exp_en = 0;
    end else if (loading) begin
      if (input_valid) begin
        m_word = {m_word[23:0], input_data};
        m_bytes++;
        if (m_bytes == 4) begin
          m_mem[m_addr] = m_word;
          m_addr = (m_addr + 1) % 4;
          m_bytes = 0;
        end
      end
      if (input_end) begin
        loading = 0; running = 1; m_bytes = 0;
      end
    end else if (running) begin
      exp_inst = m_mem[pc];
      exp_pn = 2'((int'(pc) + 1) % 4);
      exp_p1n = 2'((int'(pc1) + 1) % 4);
      exp_en = 1;
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("model_en", {31'b0, inst_enable}, {31'b0, exp_en});
      if (exp_en) begin
        chk("model_inst", inst, exp_inst);
        chk("model_pc_next", {30'b0, pc_next}, {30'b0, exp_pn});
        chk("model_pc1_next", {30'b0, pc1_next}, {30'b0, exp_p1n});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    input_valid = 1; input_data = b; tick();
    input_valid = 0; tick();
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask
  task automatic start_load();
    input_start = 1; tick(); input_start = 0;
  endtask
  task automatic end_load();
    input_end = 1; tick(); input_end = 0;
  endtask
  task automatic fetch(input logic [1:0] p, input logic [1:0] q);
    pc = p; pc1 = q; tick();
  endtask

  logic [31:0] words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    tick(); tick();
    chk_on = 1;
    chk("rst_inst", inst, 0);
    chk("rst_en", {31'b0, inst_enable}, 0);
    chk("rst_pc_next", {30'b0, pc_next}, 0);
    chk("rst_pc1_next", {30'b0, pc1_next}, 0);
    reset = 0;
    tick();
    chk("idle_en", {31'b0, inst_enable}, 0);

    start_load(); send_word(32'h00C21004); end_load();
    chk("load_en_low", {31'b0, inst_enable}, 0);
    fetch(0, 1);
    chk("single_inst", inst, 32'h00C21004);
    chk("single_en", {31'b0, inst_enable}, 1);
    chk("single_pc_next", {30'b0, pc_next}, 1);
    chk("single_pc1_next", {30'b0, pc1_next}, 2);

    start_load();
    for (int i = 0; i < 4; i++) send_word(words[i]);
    end_load();
    for (int i = 0; i < 4; i++) begin
      fetch(2'(i), 2'(i + 1));
      chk("full_inst", inst, words[i]);
    end
    chk("wrap_pc_next", {30'b0, pc_next}, 0);
    chk("wrap_pc1_next", {30'b0, pc1_next}, 1);

    start_load();
    for (int i = 0; i < 4; i++) send_word(words[i]);
    send_word(32'hAAAAAAAA); end_load();
    fetch(0, 1); chk("ldwrap_mem0", inst, 32'hAAAAAAAA);
    fetch(1, 2); chk("ldwrap_mem1", inst, 32'h22222222);

    start_load();
    for (int i = 0; i < 4; i++) send_word(32'h01010101 * (i + 1));
    send_byte(8'hEE); send_byte(8'hFF); end_load();
    for (int i = 0; i < 4; i++) begin
      fetch(2'(i), 2'(i + 1));
      chk("partial_mem", inst, 32'h01010101 * (i + 1));
    end

    start_load();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    input_valid = 1; input_data = 8'h78; input_end = 1; tick();
    input_valid = 0; input_end = 0;
    fetch(0, 1); chk("end_with_byte", inst, 32'h12345678);
    fetch(1, 2); chk("end_with_byte_m1", inst, 32'h02020202);

    input_start = 1; tick(); input_start = 0;
    chk("reload_en_drop", {31'b0, inst_enable}, 0);
    send_word(32'hCAFEF00D); end_load();
    fetch(0, 1); chk("reload_mem0", inst, 32'hCAFEF00D);
    fetch(1, 2); chk("reload_mem1", inst, 32'h02020202);

    start_load(); send_byte(8'hDE); send_byte(8'hAD);
    reset = 1; tick(); reset = 0;
    chk("midrst_en", {31'b0, inst_enable}, 0);
    chk("midrst_inst", inst, 0);
    start_load(); end_load();
    fetch(0, 1); chk("midrst_mem0", inst, 32'hCAFEF00D);
    fetch(3, 0); chk("midrst_mem3", inst, 32'h04040404);
    chk("midrst_pc_next", {30'b0, pc_next}, 0);
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage with an on-chip instruction memory of 2^INST_MEM_WIDTH 32-bit words.
- A byte-serial program loader fills the memory before execution.
- After loading, the block returns the instruction at the supplied pc each cycle, together with incremented pc values for the next fetch.
- It sits between the program loader (UART/host side) and the decode stage.

Parameters:
- INST_MEM_WIDTH, default 2: address width of the instruction memory. Depth = 2^INST_MEM_WIDTH words of 32 bits. Also the width of all pc ports.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  input  INST_MEM_WIDTH  fetch address.
- pc1  input  INST_MEM_WIDTH  companion address (normally pc+1).
- input_data  input  8  loader byte.
- input_start  input  1  loader: begin program load.
- input_end  input  1  loader: program load complete.
- input_valid  input  1  loader: input_data valid this cycle.
- inst  output  32  fetched instruction.
- inst_enable  output  1  inst/pc_next/pc1_next valid.
- pc_next  output  INST_MEM_WIDTH  pc+1 for the next fetch.
- pc1_next  output  INST_MEM_WIDTH  pc1+1 for the next fetch.

Behaviour:
- Clocking and reset:
  - One clock (CLK); reset is synchronous and active-high.
  - On reset: state=IDLE, load address=0, byte count=0, byte shift register=0, inst=0, inst_enable=0, pc_next=0, pc1_next=0.
  - Memory contents are not cleared by reset.
- States: IDLE, LOAD, RUN.
- IDLE:
  - outputs held at their reset values.
  - input_start=1 -> LOAD; load address=0, byte count=0.
- LOAD:
  - Each cycle with input_valid=1 accepts one byte. Words are assembled big-endian: first byte -> inst bits [31:24], fourth byte -> [7:0].
  - A valid held high for N cycles accepts N bytes.
  - On the 4th byte: the assembled word is written to mem[load address]; load address increments, wrapping modulo depth so that further words overwrite from 0; byte count returns to 0.
  - input_end=1 -> RUN on the next edge. A valid byte in the same cycle is accepted first, including a completing 4th-byte write. Any partial word (byte count 1-3) is discarded.
  - input_start=1 in LOAD restarts loading: address=0, count=0. start has priority over end.
  - inst_enable=0 throughout LOAD.
- RUN, every cycle (all registered, 1-cycle latency, aligned with each other):
  - inst <= mem[pc]
  - pc_next <= pc+1
  - pc1_next <= pc1+1
  - inst_enable <= 1
  - Increments are modulo 2^INST_MEM_WIDTH (wrap: all-ones -> 0).
  - input_start=1 in RUN -> LOAD (reload): address=0, count=0, inst_enable <= 0 on that edge.
  - input_valid and input_end are ignored in RUN and IDLE.
- Memory: synchronous write, one write port (loader) and one read port (fetch). No read-during-write hazard, because they are never active in the same state.
- Reset has priority over all other inputs, including mid-word during LOAD: the partial word is lost and previously written words remain.
- X/undriven loader inputs before reset are don't-care; the block must be reset before use.

Test Plan:
- Reset: hold reset 2 cycles -> inst=0, inst_enable=0, pc_next=0, pc1_next=0.
- Single-word load: start, then bytes 0x00, 0xC2, 0x10, 0x04 each as a one-cycle valid pulse, then end. Set pc=0, pc1=1 -> one cycle later inst=0x00C21004, inst_enable=1, pc_next=1, pc1_next=2.
- Full-memory load with INST_MEM_WIDTH=2: load 0x11111111, 0x22222222, 0x33333333, 0x44444444. Fetch pc=0..3 -> the matching words. pc=3 -> pc_next=0 (wrap).
- Address wrap on load: 5 words loaded, the 5th is 0xAAAAAAAA -> mem[0]=0xAAAAAAAA, mem[1]=0x22222222 unchanged.
- Partial word: 4 words, then 2 extra bytes, then end -> partial discarded, memory holds the 4 words. end asserted with a 4th-byte valid -> that word is written.
- Reload and reset mid-load:
  - start during RUN -> inst_enable drops next cycle; a new word written at address 0.
  - reset after 2 bytes -> IDLE, inst_enable=0, previously loaded words still fetchable after a new start/end.
